alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 32-bit combinational ALU. It accepts operation requests (ALU_pkg op code plus two operands) from two independent clients over valid/ready handshakes. It registers the winning request, drives the ALU from those registers, and captures the result and zero flag. It returns them on a single tagged response channel with backpressure. It sits between the decode/execute clients (e.g. integer pipe and address/branch unit) and the ALU instance.

---
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a shared combinational ALU.
// Optional feature: define ALU_ARB_OPCHECK_EN to flag op codes outside the ten ALU_pkg ops.
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_zf,
  output logic         rsp_err,
  output logic [3:0]   alu_ctrl,
  output logic [W-1:0] alu_din1,
  output logic [W-1:0] alu_din2,
  input  logic [W-1:0] alu_dout,
  input  logic         alu_zf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]   state;
  logic         last_grant;
  logic [3:0]   iss_op;
  logic [W-1:0] iss_a;
  logic [W-1:0] iss_b;
  logic         iss_id;

  logic         grant_id;
  logic         accept;
  logic [3:0]   sel_op;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && req1_valid && grant_id;

  assign sel_op = grant_id ? req1_op : req0_op;
  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;

  // The ALU sees the issue registers in every state, so its delay sits between two register stages.
  assign alu_ctrl = iss_op;
  assign alu_din1 = iss_a;
  assign alu_din2 = iss_b;

`ifdef ALU_ARB_OPCHECK_EN
  // Legal ops are encoded 0 (ADD) through 9 (SLTU); 10..15 are unused codes.
  localparam logic [3:0] LAST_OP = 4'd9;

  logic iss_err;
  logic rsp_err_q;

  assign rsp_err = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_err   <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        iss_err <= (sel_op > LAST_OP);
      end
      if (state == EXEC) begin
        rsp_err_q <= iss_err;
      end
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      iss_op     <= '0;
      iss_a      <= '0;
      iss_b      <= '0;
      iss_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_zf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            iss_op     <= sel_op;
            iss_a      <= sel_a;
            iss_b      <= sel_b;
            iss_id     <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
`ifdef ALU_ARB_OPCHECK_EN
          rsp_data <= iss_err ? '0 : alu_dout;
          rsp_zf   <= iss_err ? 1'b0 : alu_zf;
`else
          rsp_data <= alu_dout;
          rsp_zf   <= alu_zf;
`endif
          rsp_id    <= iss_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push expected responses, a negedge monitor pops and compares.
module tb_alu_arbiter;

  localparam int W = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  typedef struct packed {
    logic          id;
    logic [W-1:0]  data;
    logic          zf;
    logic          err;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp_valid, rsp_id, rsp_zf, rsp_err;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_data;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_din1, alu_din2, alu_dout;
  logic         alu_zf;

  int total = 0;
  int bad = 0;
  rsp_t exp_q[$];
  rsp_t mon_e;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zf(rsp_zf), .rsp_err(rsp_err),
    .alu_ctrl(alu_ctrl), .alu_din1(alu_din1), .alu_din2(alu_din2),
    .alu_dout(alu_dout), .alu_zf(alu_zf)
  );

  // Behavioural stand-in for the shared ALU; unused codes return 0.
  always_comb begin
    alu_dout = '0;
    case (alu_ctrl)
      OP_ADD:  alu_dout = alu_din1 + alu_din2;
      OP_SUB:  alu_dout = alu_din1 - alu_din2;
      OP_AND:  alu_dout = alu_din1 & alu_din2;
      OP_OR:   alu_dout = alu_din1 | alu_din2;
      OP_XOR:  alu_dout = alu_din1 ^ alu_din2;
      OP_SLL:  alu_dout = alu_din1 << alu_din2[4:0];
      OP_SRL:  alu_dout = alu_din1 >> alu_din2[4:0];
      OP_SRA:  alu_dout = $unsigned($signed(alu_din1) >>> alu_din2[4:0]);
      OP_SLT:  alu_dout = {31'd0, $signed(alu_din1) < $signed(alu_din2)};
      OP_SLTU: alu_dout = {31'd0, alu_din1 < alu_din2};
      default: alu_dout = '0;
    endcase
    alu_zf = (alu_dout == '0);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A response is consumed at the next rising edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got id=%0d data=0x%0h, expected no response", rsp_id, rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id",   {31'd0, rsp_id},  {31'd0, mon_e.id});
        check("rsp_data", rsp_data,          mon_e.data);
        check("rsp_zf",   {31'd0, rsp_zf},   {31'd0, mon_e.zf});
        check("rsp_err",  {31'd0, rsp_err},  {31'd0, mon_e.err});
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_rsp_id",    {31'd0, rsp_id},    0);
    check("rst_rsp_data",  rsp_data,           0);
    check("rst_rsp_zf",    {31'd0, rsp_zf},    0);
    check("rst_rsp_err",   {31'd0, rsp_err},   0);
    check("rst_alu_ctrl",  {28'd0, alu_ctrl},  0);
    check("rst_alu_din1",  alu_din1,           0);
    check("rst_alu_din2",  alu_din2,           0);
    check("rst_req0_ready", {31'd0, req0_ready}, 0);
    check("rst_req1_ready", {31'd0, req1_ready}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive0(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input rsp_t e);
    int n;
    req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req0_ready && n < 50);
    if (!req0_ready) begin
      check("req0_accept_timeout", {31'd0, req0_ready}, 1);
    end else begin
      @(posedge clk);
      if (push) exp_q.push_back(e);
    end
    #1 req0_valid = 1'b0;
  endtask

  task automatic drive1(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input rsp_t e);
    int n;
    req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req1_ready && n < 50);
    if (!req1_ready) begin
      check("req1_accept_timeout", {31'd0, req1_ready}, 1);
    end else begin
      @(posedge clk);
      if (push) exp_q.push_back(e);
    end
    #1 req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rsp_t e;
    #2 check_reset_vals();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single ADD: ready in the same cycle, response two edges after valid rises.
    @(posedge clk);
    #1 req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 5; req0_b = 7;
    #1 check("add_req0_ready", {31'd0, req0_ready}, 1);
    check("add_req1_ready", {31'd0, req1_ready}, 0);
    @(posedge clk);
    exp_q.push_back('{id: 1'b0, data: 32'd12, zf: 1'b0, err: 1'b0});
    #1 req0_valid = 1'b0;
    @(negedge clk) check("lat_exec_valid", {31'd0, rsp_valid}, 0);
    @(negedge clk) check("lat_resp_valid", {31'd0, rsp_valid}, 1);
    @(posedge clk);
    #1;
    drive1(OP_SUB, 9, 9, 1, '{id: 1'b1, data: 32'd0, zf: 1'b1, err: 1'b0});
    drive0(OP_SLT, 32'hFFFF_FFFF, 1, 1, '{id: 1'b0, data: 32'd1, zf: 1'b0, err: 1'b0});
    wait_drain();

    // Contention from reset: req0 must win first, then strict alternation.
    do_reset();
    exp_q.push_back('{id: 1'b0, data: 32'd2,    zf: 1'b0, err: 1'b0});
    exp_q.push_back('{id: 1'b1, data: 32'hFF,   zf: 1'b0, err: 1'b0});
    exp_q.push_back('{id: 1'b0, data: 32'd2,    zf: 1'b0, err: 1'b0});
    exp_q.push_back('{id: 1'b1, data: 32'hFF,   zf: 1'b0, err: 1'b0});
    fork
      begin
        drive0(OP_ADD, 1, 1, 0, '0);
        drive0(OP_ADD, 1, 1, 0, '0);
      end
      begin
        drive1(OP_OR, 32'hF0, 32'h0F, 0, '0);
        drive1(OP_OR, 32'hF0, 32'h0F, 0, '0);
      end
    join
    wait_drain();

    // Backpressure: response held stable for four cycles, no grants meanwhile.
    rsp_ready = 1'b0;
    drive0(OP_ADD, 3, 4, 1, '{id: 1'b0, data: 32'd7, zf: 1'b0, err: 1'b0});
    req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'hFF00; req1_b = 32'h0FF0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid}, 1);
      check("stall_id",    {31'd0, rsp_id},    0);
      check("stall_data",  rsp_data,           7);
      check("stall_ready0", {31'd0, req0_ready}, 0);
      check("stall_ready1", {31'd0, req1_ready}, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_stall_valid", {31'd0, rsp_valid}, 0);
    check("post_stall_idle_ready1", {31'd0, req1_ready}, 1);
    @(posedge clk);
    exp_q.push_back('{id: 1'b1, data: 32'hF0F0, zf: 1'b0, err: 1'b0});
    #1 req1_valid = 1'b0;
    wait_drain();

    // Reset during EXEC of an SRA: nothing must come back.
    @(posedge clk);
    #1 req0_valid = 1'b1; req0_op = OP_SRA; req0_a = 32'h8000_0000; req0_b = 4;
    #1 check("sra_req0_ready", {31'd0, req0_ready}, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    req0_valid = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("no_rsp_after_reset", {31'd0, rsp_valid}, 0);
    drive0(OP_SRA, 32'h8000_0000, 4, 1, '{id: 1'b0, data: 32'hF800_0000, zf: 1'b0, err: 1'b0});
    wait_drain();

    // Unused op code.
`ifdef ALU_ARB_OPCHECK_EN
    e = '{id: 1'b1, data: 32'd0, zf: 1'b0, err: 1'b1};
`else
    e = '{id: 1'b1, data: 32'd0, zf: 1'b1, err: 1'b0};
`endif
    drive1(4'hC, 1, 2, 1, e);
    drive0(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, '{id: 1'b0, data: 32'h00F0_00F0, zf: 1'b0, err: 1'b0});
    wait_drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
